sram_cp_readout: RTL and testbench

//  Parametrised charge-pulsation readout sequencer for the CIM SRAM macro. Drives the set/comp/wait_

---
 rtl/sram_cp_readout.sv | 190 +++++++++++++++++++
 tb/tb_sram_cp_readout.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_cp_readout.sv
// sram_cp_readout
//    Charge-pulsation readout sequencer for the CIM SRAM macro. On start it
//    walks SET -> COMP (PULSE_CYC cycles) -> WAIT, captures the whole CIM
//    bit-line word at the end of WAIT, then streams it out one column group
//    per valid/ready handshake, true or inverted per the latched mode.
//
//    Optional build macro: SRAM_CP_PARITY_EN adds output q_par (= ^q).
//
// Ports
//    clk, rst      rising-edge clock, synchronous active-high reset
//    start         conversion request, honoured only while idle
//    model         1: q = ~bit-line, 0: q = bit-line (latched at start)
//    inbit         1: read disabled, every group reads all-ones (latched at start)
//    data_in_cim   raw bit-line word, group g = [g*GRP_W +: GRP_W]
//    set/comp/wait_ registered one-hot phase strobes
//    busy          high whenever the sequencer is not idle
//    q, q_grp      current output group and its index
//    q_valid       q/q_grp valid, accepted when q_valid & q_ready at clk edge
//    q_ready       consumer ready
//    done          one-cycle pulse after the last group is accepted
//    q_par         (SRAM_CP_PARITY_EN only) parity of q
module sram_cp_readout #(
   parameter int GRP_W     = 192,
   parameter int NUM_GRP   = 3,
   parameter int PULSE_CYC = 4,
   parameter int GI_W      = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     model,
   input  logic                     inbit,
   input  logic [GRP_W*NUM_GRP-1:0] data_in_cim,
   output logic                     set,
   output logic                     comp,
   output logic                     wait_,
   output logic                     busy,
   output logic [GRP_W-1:0]         q,
   output logic [GI_W-1:0]          q_grp,
   output logic                     q_valid,
   input  logic                     q_ready,
   output logic                     done
`ifdef SRAM_CP_PARITY_EN
   ,
   output logic                     q_par
`endif
);

   localparam int CAP_W = GRP_W * NUM_GRP;
   localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC - 1);
   localparam logic [GI_W-1:0]  LAST_GRP = GI_W'(NUM_GRP - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SET,
      ST_COMP,
      ST_WAIT,
      ST_OUT
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CAP_W-1:0]  cap, cap_nxt;
   logic              model_r, model_nxt;
   logic              inbit_r, inbit_nxt;
   logic              set_nxt, comp_nxt, wait_nxt, busy_nxt, valid_nxt, done_nxt;
   logic [GRP_W-1:0]  q_nxt;
   logic [GI_W-1:0]   grp_nxt;

   function automatic logic [GRP_W-1:0] grp_sel(input logic [CAP_W-1:0] w,
                                                input logic [GI_W-1:0]  idx);
      grp_sel = '0;
      for (int unsigned g = 0; g < NUM_GRP; g++) begin
         if (idx == GI_W'(g)) grp_sel = w[g*GRP_W +: GRP_W];
      end
   endfunction

   function automatic logic [GRP_W-1:0] fmt(input logic [GRP_W-1:0] g,
                                            input logic            inv,
                                            input logic            dis);
      if (dis)      fmt = '1;
      else if (inv) fmt = ~g;
      else          fmt = g;
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cap_nxt   = cap;
      model_nxt = model_r;
      inbit_nxt = inbit_r;
      set_nxt   = 1'b0;
      comp_nxt  = 1'b0;
      wait_nxt  = 1'b0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      q_nxt     = q;
      grp_nxt   = q_grp;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SET;
               set_nxt   = 1'b1;
               model_nxt = model;
               inbit_nxt = inbit;
            end
         end
         ST_SET: begin
            state_nxt = ST_COMP;
            comp_nxt  = 1'b1;
            cnt_nxt   = CNT_LOAD;
         end
         ST_COMP: begin
            if (cnt == '0) begin
               state_nxt = ST_WAIT;
               wait_nxt  = 1'b1;
            end else begin
               cnt_nxt  = cnt - CNT_W'(1);
               comp_nxt = 1'b1;
            end
         end
         ST_WAIT: begin
            // q is registered, so the first beat is formatted straight from the
            // word being captured on this same edge.
            cap_nxt   = data_in_cim;
            state_nxt = ST_OUT;
            valid_nxt = 1'b1;
            grp_nxt   = '0;
            q_nxt     = fmt(data_in_cim[GRP_W-1:0], model_r, inbit_r);
         end
         ST_OUT: begin
            valid_nxt = 1'b1;
            if (q_ready) begin
               if (q_grp == LAST_GRP) begin
                  state_nxt = ST_IDLE;
                  valid_nxt = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  grp_nxt = q_grp + GI_W'(1);
                  q_nxt   = fmt(grp_sel(cap, q_grp + GI_W'(1)), model_r, inbit_r);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         cap     <= '0;
         model_r <= 1'b0;
         inbit_r <= 1'b0;
         set     <= 1'b0;
         comp    <= 1'b0;
         wait_   <= 1'b0;
         busy    <= 1'b0;
         q_valid <= 1'b0;
         done    <= 1'b0;
         q       <= '0;
         q_grp   <= '0;
`ifdef SRAM_CP_PARITY_EN
         q_par   <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         cap     <= cap_nxt;
         model_r <= model_nxt;
         inbit_r <= inbit_nxt;
         set     <= set_nxt;
         comp    <= comp_nxt;
         wait_   <= wait_nxt;
         busy    <= busy_nxt;
         q_valid <= valid_nxt;
         done    <= done_nxt;
         q       <= q_nxt;
         q_grp   <= grp_nxt;
`ifdef SRAM_CP_PARITY_EN
         q_par   <= ^q_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_sram_cp_readout.sv
// tb_sram_cp_readout
//    Directed bench for sram_cp_readout at GRP_W=192, NUM_GRP=3, PULSE_CYC=4.
//    Cycle numbers are counted from the edge that samples start (edge 0).
module tb_sram_cp_readout;

   localparam int GRP_W     = 192;
   localparam int NUM_GRP   = 3;
   localparam int PULSE_CYC = 4;
   localparam int GI_W      = 2;
   localparam int CAP_W     = GRP_W * NUM_GRP;

   localparam logic [GRP_W-1:0] G_ONES = '1;
   localparam logic [GRP_W-1:0] G_ZERO = '0;
   localparam logic [GRP_W-1:0] G_A5   = {24{8'hA5}};
   localparam logic [GRP_W-1:0] G_5A   = {24{8'h5A}};

   logic             clk;
   logic             rst;
   logic             start;
   logic             model;
   logic             inbit;
   logic [CAP_W-1:0] din;
   logic             set, comp, wait_, busy, q_valid, done, q_ready;
   logic [GRP_W-1:0] q;
   logic [GI_W-1:0]  q_grp;
`ifdef SRAM_CP_PARITY_EN
   logic             q_par;
`endif
   logic [5:0]       ctrl;

   int vectors = 0;
   int errors  = 0;

   assign ctrl = {set, comp, wait_, busy, q_valid, done};

   sram_cp_readout #(
      .GRP_W    (GRP_W),
      .NUM_GRP  (NUM_GRP),
      .PULSE_CYC(PULSE_CYC),
      .GI_W     (GI_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .model      (model),
      .inbit      (inbit),
      .data_in_cim(din),
      .set        (set),
      .comp       (comp),
      .wait_      (wait_),
      .busy       (busy),
      .q          (q),
      .q_grp      (q_grp),
      .q_valid    (q_valid),
      .q_ready    (q_ready),
      .done       (done)
`ifdef SRAM_CP_PARITY_EN
      ,
      .q_par      (q_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected {set,comp,wait_,busy,q_valid,done} in cycle c of a conversion
   // whose first group is held for `stall` extra cycles.
   function automatic logic [5:0] exp_ctrl(input int c, input int stall);
      logic s, cp, w, b, v, d;
      s  = (c == 1);
      cp = (c >= 2 && c <= 5);
      w  = (c == 6);
      b  = (c >= 1 && c <= 9 + stall);
      v  = (c >= 7 && c <= 9 + stall);
      d  = (c == 10 + stall);
      return {s, cp, w, b, v, d};
   endfunction

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; model = 1'b0; inbit = 1'b0; q_ready = 1'b0; din = '0;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if (ctrl !== 6'b0 || q !== G_ZERO || q_grp !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: ctrl=%b q=%h q_grp=%0d, required ctrl=000000 q=0 q_grp=0",
                     i, ctrl, q, q_grp);
         end
`ifdef SRAM_CP_PARITY_EN
         vectors++;
         if (q_par !== 1'b0) begin
            errors++;
            $display("FAIL reset_par cyc%0d: q_par=%b required 0", i, q_par);
         end
`endif
         tick();
      end
   endtask

   task automatic test_invert;
      logic [GRP_W-1:0] eq [3];
      eq[0] = G_ONES; eq[1] = G_ZERO; eq[2] = G_5A;
      din = {G_A5, G_ONES, G_ZERO};
      model = 1'b1; inbit = 1'b0; q_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         vectors++;
         if (ctrl !== exp_ctrl(c, 0)) begin
            errors++;
            $display("FAIL invert_ctrl cyc%0d: ctrl=%b required %b", c, ctrl, exp_ctrl(c, 0));
         end
         if (c >= 7 && c <= 9) begin
            vectors++;
            if (q !== eq[c-7] || q_grp !== GI_W'(c - 7)) begin
               errors++;
               $display("FAIL invert_q cyc%0d: q=%h q_grp=%0d, required q=%h q_grp=%0d",
                        c, q, q_grp, eq[c-7], c - 7);
            end
`ifdef SRAM_CP_PARITY_EN
            vectors++;
            if (q_par !== ^eq[c-7]) begin
               errors++;
               $display("FAIL invert_par cyc%0d: q_par=%b required %b", c, q_par, ^eq[c-7]);
            end
`endif
         end
         if (c == 10) begin
            vectors++;
            if (q !== G_5A) begin
               errors++;
               $display("FAIL invert_hold: q=%h required %h", q, G_5A);
            end
         end
         tick();
      end
   endtask

   task automatic test_stall;
      logic [GRP_W-1:0] eq [3];
      int idx;
      eq[0] = G_ZERO; eq[1] = G_ONES; eq[2] = G_A5;
      din = {G_A5, G_ONES, G_ZERO};
      model = 1'b0; inbit = 1'b0; q_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         q_ready = !(c >= 7 && c <= 10);
         vectors++;
         if (ctrl !== exp_ctrl(c, 4)) begin
            errors++;
            $display("FAIL stall_ctrl cyc%0d: ctrl=%b required %b", c, ctrl, exp_ctrl(c, 4));
         end
         if (c >= 7 && c <= 13) begin
            idx = (c <= 11) ? 0 : c - 11;
            vectors++;
            if (q !== eq[idx] || q_grp !== GI_W'(idx)) begin
               errors++;
               $display("FAIL stall_q cyc%0d: q=%h q_grp=%0d, required q=%h q_grp=%0d",
                        c, q, q_grp, eq[idx], idx);
            end
         end
         tick();
      end
      q_ready = 1'b1;
   endtask

   task automatic test_inbit;
      int done_cnt = 0;
      for (int i = 0; i < CAP_W / 32; i++) din[i*32 +: 32] = $urandom;
      model = 1'b0; inbit = 1'b1; q_ready = 1'b1; start = 1'b1;
      tick();
      // Mode inputs are latched at start; flipping them now must not matter.
      start = 1'b0; inbit = 1'b0; model = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         vectors++;
         if (ctrl !== exp_ctrl(c, 0)) begin
            errors++;
            $display("FAIL inbit_ctrl cyc%0d: ctrl=%b required %b", c, ctrl, exp_ctrl(c, 0));
         end
         if (c >= 7 && c <= 9) begin
            vectors++;
            if (q !== G_ONES || q_grp !== GI_W'(c - 7)) begin
               errors++;
               $display("FAIL inbit_q cyc%0d: q=%h q_grp=%0d, required all-ones q_grp=%0d",
                        c, q, q_grp, c - 7);
            end
         end
         if (done === 1'b1) done_cnt++;
         tick();
      end
      vectors++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL inbit_done_count: %0d pulses, required 1", done_cnt);
      end
   endtask

   task automatic test_reset_mid;
      din = {G_A5, G_ONES, G_ZERO};
      model = 1'b1; inbit = 1'b0; q_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      vectors++;
      if (ctrl !== exp_ctrl(3, 0)) begin
         errors++;
         $display("FAIL rstmid_comp: ctrl=%b required %b", ctrl, exp_ctrl(3, 0));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ctrl !== 6'b0 || q !== G_ZERO || q_grp !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_comp_idle cyc%0d: ctrl=%b q=%h q_grp=%0d, required all 0",
                     i, ctrl, q, q_grp);
         end
         tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         vectors++;
         if (ctrl !== exp_ctrl(c, 0)) begin
            errors++;
            $display("FAIL rstmid_ctrl cyc%0d: ctrl=%b required %b", c, ctrl, exp_ctrl(c, 0));
         end
         if (c == 8) begin
            vectors++;
            if (q !== G_ZERO || q_grp !== 2'd1) begin
               errors++;
               $display("FAIL rstmid_beat1: q=%h q_grp=%0d, required q=0 q_grp=1", q, q_grp);
            end
            rst = 1'b1;
         end
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ctrl !== 6'b0 || q !== G_ZERO || q_grp !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_out_idle cyc%0d: ctrl=%b q=%h q_grp=%0d, required all 0",
                     i, ctrl, q, q_grp);
         end
         tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         vectors++;
         if (ctrl !== exp_ctrl(c, 0)) begin
            errors++;
            $display("FAIL rstmid_restart cyc%0d: ctrl=%b required %b", c, ctrl, exp_ctrl(c, 0));
         end
         if (c == 9) begin
            vectors++;
            if (q !== G_5A || q_grp !== 2'd2) begin
               errors++;
               $display("FAIL rstmid_restart_q: q=%h q_grp=%0d, required q=%h q_grp=2", q, q_grp, G_5A);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back;
      logic [CAP_W-1:0] rnd [32];
      logic [CAP_W-1:0] w;
      logic [GRP_W-1:0] eq;
      logic [5:0]       ec;
      int cm, base;
      for (int k = 0; k < 32; k++)
         for (int i = 0; i < CAP_W / 32; i++) rnd[k][i*32 +: 32] = $urandom;
      model = 1'b1; inbit = 1'b0; q_ready = 1'b1; start = 1'b1;
      for (int c = 0; c <= 31; c++) begin
         din = rnd[c];
         if (c == 30) start = 1'b0;
         if (c >= 1) begin
            cm = ((c - 1) % 10) + 1;
            ec = (c == 31) ? 6'b0 : exp_ctrl(cm, 0);
            vectors++;
            if (ctrl !== ec) begin
               errors++;
               $display("FAIL b2b_ctrl cyc%0d: ctrl=%b required %b", c, ctrl, ec);
            end
            if (c < 31 && cm >= 7 && cm <= 9) begin
               base = c - cm;
               w    = rnd[base + 6];
               eq   = ~w[(cm-7)*GRP_W +: GRP_W];
               vectors++;
               if (q !== eq || q_grp !== GI_W'(cm - 7)) begin
                  errors++;
                  $display("FAIL b2b_q cyc%0d: q=%h q_grp=%0d, required q=%h q_grp=%0d",
                           c, q, q_grp, eq, cm - 7);
               end
`ifdef SRAM_CP_PARITY_EN
               vectors++;
               if (q_par !== ^eq) begin
                  errors++;
                  $display("FAIL b2b_par cyc%0d: q_par=%b required %b", c, q_par, ^eq);
               end
`endif
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_invert();
      test_stall();
      test_inbit();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
